// File: rtl/interrupt_pkg.sv
// Shared interrupt definitions: mcause codes, request FSM states and the
// fixed-priority cause selector used by the machine interrupt unit.
package interrupt_pkg;

    localparam logic [3:0] MsiCause = 4'd3;
    localparam logic [3:0] MtiCause = 4'd7;
    localparam logic [3:0] MeiCause = 4'd11;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Req   = 2'd1,
        Acked = 2'd2
    } irq_state_t;

    // pend is ordered {MEI, MSI, MTI}; external beats software beats timer.
    function automatic logic [3:0] prio_cause(input logic [2:0] pend);
        logic [3:0] cause;
        cause = MtiCause;
        if (pend[2]) begin
            cause = MeiCause;
        end else if (pend[1]) begin
            cause = MsiCause;
        end
        return cause;
    endfunction

endpackage

// File: rtl/sync_flop_chain.sv
// Multi-flop synchronizer bringing an asynchronous level into the clock domain.
// Output appears STAGES rising edges after the input is first sampled.
module sync_flop_chain #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clint_irq_unit.sv
// Machine interrupt unit: registers MSIP/MTIP/MEIP, masks them with mie and
// mstatus.MIE, and offers one prioritized request to the core via req/ack.
module clint_irq_unit
    import interrupt_pkg::*;
#(
    parameter int DATA_SIZE   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] msip,
    input  logic [63:0]          mtime,
    input  logic [63:0]          mtimecmp,
    input  logic                 ext_irq,
    input  logic                 mie_msie,
    input  logic                 mie_mtie,
    input  logic                 mie_meie,
    input  logic                 mstatus_mie,
    input  logic                 irq_ack,
    output logic                 mip_msip,
    output logic                 mip_mtip,
    output logic                 mip_meip,
    output logic                 irq_req,
    output logic [3:0]           irq_cause
);

    logic       mip_msip_q;
    logic       hi_gt_q, hi_eq_q, lo_ge_q;
    logic       mip_mtip_q;
    logic       meip_sync;
    logic [2:0] pend;
    irq_state_t state_q, state_d;
    logic [3:0] irq_cause_q, irq_cause_d;

    // Only msip[0] carries the software interrupt.
    logic unused_msip_hi;
    assign unused_msip_hi = ^msip[DATA_SIZE-1:1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mip_msip_q <= 1'b0;
        end else begin
            mip_msip_q <= msip[0];
        end
    end

    // Split the 64-bit unsigned compare into halves to shorten the path.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_gt_q    <= 1'b0;
            hi_eq_q    <= 1'b0;
            lo_ge_q    <= 1'b0;
            mip_mtip_q <= 1'b0;
        end else begin
            hi_gt_q    <= mtime[63:32] >  mtimecmp[63:32];
            hi_eq_q    <= mtime[63:32] == mtimecmp[63:32];
            lo_ge_q    <= mtime[31:0]  >= mtimecmp[31:0];
            mip_mtip_q <= hi_gt_q | (hi_eq_q & lo_ge_q);
        end
    end

    sync_flop_chain #(
        .STAGES(SYNC_STAGES)
    ) u_ext_sync (
        .clk_i (clock),
        .rst_ni(reset),
        .d_i   (ext_irq),
        .q_o   (meip_sync)
    );

    assign pend = {meip_sync  & mie_meie,
                   mip_msip_q & mie_msie,
                   mip_mtip_q & mie_mtie} & {3{mstatus_mie}};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= Idle;
            irq_cause_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            irq_cause_q <= irq_cause_d;
        end
    end

    // Cause is captured only on Idle->Req so it stays stable while requesting.
    always_comb begin
        state_d     = state_q;
        irq_cause_d = irq_cause_q;
        case (state_q)
            Idle: begin
                if (|pend) begin
                    state_d     = Req;
                    irq_cause_d = prio_cause(pend);
                end
            end
            Req: begin
                if (irq_ack) begin
                    state_d = Acked;
                end else if (pend == 3'b000) begin
                    state_d = Idle;
                end
            end
            Acked: state_d = Idle;
            default: state_d = Idle;
        endcase
    end

    assign mip_msip  = mip_msip_q;
    assign mip_mtip  = mip_mtip_q;
    assign mip_meip  = meip_sync;
    assign irq_req   = (state_q == Req);
    assign irq_cause = irq_cause_q;

endmodule
